// File: rtl/md_if.sv
// md_if: MD unit bus carrying EX issue and operands in, and busy/stall/done/HI/LO out.
//   master: drives flush, issue_valid, md_func, md_sign, src_a, src_b, hi_rd, lo_rd
//   slave : drives busy, md_stall, done, hi, lo
interface md_if;
  logic        flush;
  logic        issue_valid;
  logic [2:0]  md_func;
  logic        md_sign;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_rd;
  logic        lo_rd;
  logic        busy;
  logic        md_stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (
    output flush, issue_valid, md_func, md_sign, src_a, src_b, hi_rd, lo_rd,
    input  busy, md_stall, done, hi, lo
  );
  modport slave (
    input  flush, issue_valid, md_func, md_sign, src_a, src_b, hi_rd, lo_rd,
    output busy, md_stall, done, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide unit with its own sequencer, owning HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   md    : md_if.slave (issue/operands/mfhi-mflo reads in; busy, md_stall, done, hi, lo out)
//   Optional macro MD_EARLY_OUT_EN: a divide with |a| < |b| finishes in one cycle.
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_ITERS  = 32
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] prod_q, rem_q, rem_d, prod;
  logic [31:0] dvs_q, hi_q, lo_q, a_abs, b_abs;
  logic [32:0] up;
  logic        qneg_q, rneg_q, busy_q, done_q, a_neg, b_neg, accept;
  always_comb begin
    accept = md.issue_valid && !md.flush && state_q == IDLE;
    a_neg  = md.md_sign && md.src_a[31];
    b_neg  = md.md_sign && md.src_b[31];
    a_abs  = a_neg ? -md.src_a : md.src_a;
    b_abs  = b_neg ? -md.src_b : md.src_b;
    prod   = md.md_sign ? {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b}
                        : {32'd0, md.src_a} * {32'd0, md.src_b};
    // Restoring step: shift left one, subtract divisor from upper half when it fits.
    // The shifted upper half is kept 33 bits wide since it may reach 2*divisor-1.
    up     = rem_q[63:31];
    rem_d  = (up >= {1'b0, dvs_q}) ? {up[31:0] - dvs_q, rem_q[30:0], 1'b1}
                                   : {rem_q[62:0], 1'b0};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (md.md_func == 3'd1) hi_q <= md.src_a;
          if (md.md_func == 3'd2) lo_q <= md.src_a;
          if (md.md_func == 3'd3) begin
            prod_q  <= prod;
            cnt_q   <= 6'(MUL_CYCLES - 1);
            state_q <= MUL;
            busy_q  <= 1'b1;
          end
          // Division by zero falls through as a no-op.
          if (md.md_func == 3'd4 && md.src_b != 32'd0) begin
            dvs_q  <= b_abs;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            busy_q <= 1'b1;
`ifdef MD_EARLY_OUT_EN
            // Quotient 0, remainder |a|; FIX restores the dividend's sign.
            if (a_abs < b_abs) begin
              rem_q   <= {a_abs, 32'd0};
              state_q <= FIX;
            end else begin
`else
            begin
`endif
              rem_q   <= {32'd0, a_abs};
              cnt_q   <= 6'(DIV_ITERS - 1);
              state_q <= DIV;
            end
          end
        end
        MUL: if (cnt_q == 6'd0) begin
          {hi_q, lo_q} <= prod_q;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 6'd1;
        end
        DIV: begin
          rem_q   <= rem_d;
          cnt_q   <= cnt_q - 6'd1;
          state_q <= (cnt_q == 6'd0) ? FIX : DIV;
        end
        FIX: begin
          lo_q    <= qneg_q ? -rem_q[31:0] : rem_q[31:0];
          hi_q    <= rneg_q ? -rem_q[63:32] : rem_q[63:32];
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end
  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_stall = busy_q && (md.hi_rd || md.lo_rd ||
                                  (md.issue_valid && md.md_func inside {[3'd1:3'd4]}));
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven, hand-sequenced and randomized checks of md_sequencer.
module tb_md_sequencer;
  localparam int MUL = 5;
`ifdef MD_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  md_if bus();
  md_sequencer #(.MUL_CYCLES(MUL)) dut (.clk(clk), .reset(reset), .md(bus));
  always #5 clk = ~clk;
  int n_checks = 0, n_err = 0;
  int ob_busy, ob_done, ob_stall, e_busy, e_done;
  logic [31:0] m_hi = 0, m_lo = 0;
  typedef struct {
    logic [2:0]  f;
    logic        s;
    logic [31:0] a, b, ehi, elo;
    int          ebusy;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference: results from 64-bit integer arithmetic with C-style truncating division.
  task automatic model_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic fl);
    longint x, y, q, r;
    logic [63:0] p;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    e_busy = 0;
    e_done = 0;
    if (!fl) begin
      if (f == 3'd1) m_hi = a;
      else if (f == 3'd2) m_lo = a;
      else if (f == 3'd3) begin
        p = x * y;
        m_hi = p[63:32];
        m_lo = p[31:0];
        e_busy = MUL;
        e_done = 1;
      end else if (f == 3'd4 && b != 0) begin
        q = x / y;
        r = x % y;
        m_lo = q[31:0];
        m_hi = r[31:0];
        e_busy = (EARLY && ((x < 0) ? -x : x) < ((y < 0) ? -y : y)) ? 1 : 33;
        e_done = 1;
      end
    end
  endtask
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
    model_op(f, s, a, b, fl);
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b1;
    bus.flush = fl;
    bus.md_func = f;
    bus.md_sign = s;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
    bus.md_func = 3'd0;
    ob_busy = 0;
    ob_done = 0;
    ob_stall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ob_busy += int'(bus.busy);
      ob_done += int'(bus.done);
      ob_stall += int'(bus.md_stall);
    end
  endtask
  initial begin
    vt[0] = '{3'd1, 1'b0, 32'h11, 32'h0, 32'h11, 32'h0, 0};
    vt[1] = '{3'd2, 1'b0, 32'h22, 32'h0, 32'h11, 32'h22, 0};
    vt[2] = '{3'd3, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, MUL};
    vt[3] = '{3'd3, 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL};
    vt[4] = '{3'd4, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vt[5] = '{3'd4, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33};
    vt[6] = '{3'd1, 1'b0, 32'h11, 32'h0, 32'h11, 32'd14, 0};
    vt[7] = '{3'd2, 1'b0, 32'h22, 32'h0, 32'h11, 32'h22, 0};
    vt[8] = '{3'd4, 1'b0, 32'd100, 32'd0, 32'h11, 32'h22, 0};
    vt[9] = '{3'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33};
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
    bus.md_func = 3'd0;
    bus.md_sign = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.hi_rd = 1'b0;
    bus.lo_rd = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    foreach (vt[i]) begin
      run_op(vt[i].f, vt[i].s, vt[i].a, vt[i].b, 1'b0);
      chk($sformatf("vec%0d_busy", i), 32'(ob_busy), 32'(vt[i].ebusy));
      chk($sformatf("vec%0d_done", i), 32'(ob_done), (vt[i].ebusy > 0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_hi", i), bus.hi, vt[i].ehi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vt[i].elo);
    end
    // mult followed by mflo and a held mtlo: stall every busy cycle, mtlo lands after.
    begin
      int nb, ns;
      model_op(3'd3, 1'b0, 32'd3, 32'd4, 1'b0);
      @(posedge clk);
      #1;
      bus.issue_valid = 1'b1;
      bus.md_func = 3'd3;
      bus.md_sign = 1'b0;
      bus.src_a = 32'd3;
      bus.src_b = 32'd4;
      @(posedge clk);
      #1;
      bus.md_func = 3'd2;
      bus.src_a = 32'hABCD;
      bus.lo_rd = 1'b1;
      nb = 0;
      ns = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus.busy) break;
        nb++;
        ns += int'(bus.md_stall);
      end
      chk("stall_busy_len", 32'(nb), MUL);
      chk("stall_cycles", 32'(ns), MUL);
      chk("stall_lo_prod", bus.lo, 32'd12);
      chk("stall_released", 32'(bus.md_stall), 0);
      @(posedge clk);
      #1;
      bus.issue_valid = 1'b0;
      bus.md_func = 3'd0;
      bus.lo_rd = 1'b0;
      model_op(3'd2, 1'b0, 32'hABCD, 32'd0, 1'b0);
      @(negedge clk);
      chk("mtlo_after_lo", bus.lo, 32'hABCD);
      chk("mtlo_after_hi", bus.hi, 32'd0);
      chk("mtlo_no_busy", 32'(bus.busy), 0);
      chk("mtlo_no_done", 32'(bus.done), 0);
    end
    // flushed issue is ignored
    run_op(3'd1, 1'b0, 32'hDEAD, 32'd0, 1'b1);
    chk("flush_hi", bus.hi, m_hi);
    // reset at div iteration ~10, then a clean divu
    run_op(3'd1, 1'b0, 32'h5555, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b1;
    bus.md_func = 3'd4;
    bus.md_sign = 1'b0;
    bus.src_a = 32'h1234;
    bus.src_b = 32'd5;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.md_func = 3'd0;
    repeat (10) @(negedge clk);
    chk("mid_div_busy", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_hi", bus.hi, 0);
    chk("async_rst_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 0;
    m_lo = 0;
    run_op(3'd4, 1'b0, 32'd9, 32'd3, 1'b0);
    chk("post_rst_busy", 32'(ob_busy), 33);
    chk("post_rst_lo", bus.lo, 32'd3);
    chk("post_rst_hi", bus.hi, 32'd0);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f;
      logic s, fl;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      s = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 10)) : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 3));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op(f, s, a, b, fl);
      chk($sformatf("rnd%0d_busy", i), 32'(ob_busy), 32'(e_busy));
      chk($sformatf("rnd%0d_done", i), 32'(ob_done), 32'(e_done));
      chk($sformatf("rnd%0d_stall", i), 32'(ob_stall), 0);
      chk($sformatf("rnd%0d_hi", i), bus.hi, m_hi);
      chk($sformatf("rnd%0d_lo", i), bus.lo, m_lo);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide unit with its own sequencer, sitting in EX beside the ALU.
- Accepts the decoded MD function code (mthi/mtlo/mult/div, signed or unsigned) and runs the operation over a fixed number of cycles.
- Owns the HI/LO registers.
- Raises a stall request into the pipeline stall logic whenever a later instruction needs HI/LO or the unit while it is busy.

Parameters:
MUL_CYCLES, 5, cycles from multiply acceptance to HI/LO write (legal range 1..15)
DIV_ITERS, 32, restoring-division iterations (fixed at 32 for a 32-bit datapath; not for tuning)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
flush  input  1  EX flush; suppresses this cycle's issue
issue_valid  input  1  EX holds a valid instruction
md_func  input  3  0 none, 1 mthi, 2 mtlo, 3 mult, 4 div; 5-7 treated as 0
md_sign  input  1  1 = signed mult/div
src_a  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
src_b  input  32  rt operand (divisor / multiplier)
hi_rd  input  1  EX instruction is mfhi
lo_rd  input  1  EX instruction is mflo
busy  output  1  mult/div in flight
md_stall  output  1  stall request to pipeline_stall
done  output  1  one-cycle pulse after a HI/LO result write
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset low, asynchronous): state IDLE; hi, lo, busy, done, cycle counter and internal registers all 0.
- Accept condition: issue_valid && !flush && state==IDLE.
- md_func=1 when accepted: hi<=src_a at that edge. md_func=2: lo<=src_a. No busy; done stays 0.
- md_func=3 when accepted:
  - Latch the 64-bit product, signed if md_sign, else unsigned.
  - Go to MUL with counter=MUL_CYCLES-1.
  - busy=1 from the acceptance edge.
  - On the edge where counter==0 in MUL: {hi,lo}<=product, state IDLE, busy 0.
  - busy is high for exactly MUL_CYCLES cycles.
- md_func=4 when accepted, src_b==0: divide by zero. Treated as a no-op; hi/lo unchanged, busy never asserted.
- md_func=4 when accepted, src_b!=0:
  - Latch |a|, |b| (raw values if unsigned).
  - Latch sign flags: quotient negative = sign(a)^sign(b) when signed; remainder negative = sign(a) when signed.
  - State DIV: one restoring shift-subtract step per cycle, DIV_ITERS cycles, 64-bit partial remainder register.
  - State FIX, 1 cycle: apply two's-complement negation per the flags; lo<=quotient, hi<=remainder; return to IDLE.
  - busy is high for DIV_ITERS+1 = 33 cycles.
  - Overflow case 0x80000000 / -1 (signed): lo=0x80000000, hi=0; no trap.
- done=1 for the cycle following any mult/div HI/LO write; 0 otherwise.
- md_stall = busy && ( hi_rd || lo_rd || (issue_valid && md_func!=0) ); combinational.
- Issue while busy: ignored. The stall holds the instruction in EX until busy falls; it is accepted on the first non-busy cycle.
- flush never aborts an in-flight operation; it only blocks acceptance in its own cycle.
- hi/lo are registered outputs. mfhi/mflo read them directly. The first read after busy falls sees the new result.
- Reset mid-operation: immediate return to IDLE; hi/lo=0; the partial result is discarded.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: an accepted div with |a| < |b| skips DIV/FIX. Next edge: lo<=0, hi<=src_a unchanged (sign preserved). busy high 1 cycle; done pulses.
- Not defined: every non-zero-divisor div takes the full 33 cycles.

Test Plan:
- multu a=0xFFFFFFFF, b=2 -> busy high 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE; done pulses once.
- mult signed a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB after 5 cycles.
- div signed a=-7, b=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same with divu a=100, b=7 -> lo=14, hi=2.
- divu a=100, b=0 with hi=0x11, lo=0x22 preset via mthi/mtlo -> busy stays 0; hi=0x11, lo=0x22 unchanged.
- Issue mult, next cycle assert lo_rd, and separately issue mtlo while busy -> md_stall=1 every busy cycle. mtlo is accepted on the first cycle busy=0, overwriting lo after the product write.
- Drop reset for one cycle at div iteration 10 -> busy, hi, lo go 0 asynchronously. A subsequent divu 9/3 completes correctly: lo=3, hi=0.
